mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 Port op, input, 1 bit: 0 = signed MULT, 1 = signed DIV.
REQ-006 Port a, input, 32 bits: multiplicand or dividend (two's complement).
REQ-007 Port b, input, 32 bits: multiplier or divisor (two's complement).
REQ-008 Port busy, output, 1 bit: high while not in IDLE.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port hi, output, 32 bits: high product word, or remainder.
REQ-011 Port lo, output, 32 bits: low product word, or quotient.
REQ-012 Port hi_write, output, 1 bit: HIWrite strobe.
REQ-013 Port lo_write, output, 1 bit: LOWrite strobe.
REQ-014 Port div_zero, output, 1 bit: divide-by-zero exception pulse.
REQ-015 Parameter ITER, default 32: iteration count, equal to the operand width.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, MULT, DIV and FIN.
REQ-017 In IDLE with start=1, the block SHALL latch a, b and op at that edge, then move to MULT (op=0), or to DIV (op=1, b!=0), or to FIN with div_zero set (op=1, b==0).
REQ-018 In IDLE with start=0, the block SHALL hold state and all registered outputs.
REQ-019 MULT and DIV SHALL each run exactly ITER cycles, tracked by a 5-bit iteration counter that counts 0..31; the counter SHALL clear on entry and move to FIN on the edge where the count is 31.
REQ-020 MULT SHALL perform one shift-add step per cycle on operand magnitudes and SHALL negate the 64-bit result when the operand signs differ.
REQ-021 DIV SHALL perform one restoring shift-subtract step per cycle on operand magnitudes; the quotient SHALL be negated when the signs differ, and the remainder SHALL take the sign of the dividend.
REQ-022 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wraparound, no exception).
REQ-023 FIN SHALL last exactly one cycle, then return to IDLE.
REQ-024 During FIN, done SHALL be 1; hi_write and lo_write SHALL be 1 unless div_zero=1, in which case both SHALL be 0.
REQ-025 For a normal operation, done SHALL rise exactly ITER+1 edges after the edge that sampled start; for divide-by-zero, it SHALL rise 1 edge after.
REQ-026 The hi and lo outputs SHALL update only on the edge entering FIN of a non-zero-divisor operation, and SHALL hold their values at all other times.
REQ-027 The start input SHALL be ignored while busy=1; no queueing.
REQ-028 A start asserted in the IDLE cycle that follows FIN SHALL be accepted (back-to-back operations).
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 While reset=1, the state SHALL be IDLE, and the counter, busy, done, hi, lo, hi_write, lo_write and div_zero SHALL all be 0.
REQ-031 A reset during MULT or DIV SHALL abort the operation: no done pulse, no write strobes, and hi/lo cleared.
REQ-032 After reset deasserts, the first start SHALL be sampled on the first rising edge at which reset=0.

Structure
REQ-033 The state encoding (IDLE=2'd0, MULT=2'd1, DIV=2'd2, FIN=2'd3), the op encodings and ITER SHALL live in the shared package cpu_pkg.
REQ-034 A single combinational sub-module, md_step, SHALL compute one iteration (shift-add or shift-subtract) of the 64-bit working register.
REQ-035 The FSM, counter and sign-fixup logic SHALL reside in mult_div_ctrl.

Verification
REQ-036 MULT a=7, b=0xFFFFFFFD SHALL give done at edge +33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, with hi_write=lo_write=1 for one cycle.
REQ-037 MULT a=b=0x7FFFFFFF SHALL give hi=0x3FFFFFFF and lo=0x00000001.
REQ-038 DIV a=0xFFFFFFF9 (-7), b=2 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-039 DIV with b=0, issued after a prior MULT, SHALL give done and div_zero at edge +1, no write strobes, and hi/lo unchanged.
REQ-040 A start pulsed at edges +5 and +20 of a running MULT SHALL be ignored, with exactly one done; a start in the IDLE cycle right after FIN SHALL begin a new operation.
REQ-041 Reset asserted asynchronously at edge +10 of a DIV SHALL drive busy=0 immediately and clear hi/lo, with no done pulse ever appearing.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply/divide unit: FSM state codes,
// operation codes, iteration count and an operand magnitude helper.
package cpu_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Absolute value of a two's complement word.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the 64-bit working register (combinational).
// Ports: i_op (0 shift-add multiply, 1 restoring divide), i_opd
// (multiplicand or divisor magnitude), i_work (current register),
// o_work (register after one step).
module md_step
    import cpu_pkg::*;
(
    input  logic        i_op,
    input  logic [31:0] i_opd,
    input  logic [63:0] i_work,
    output logic [63:0] o_work
);

    logic [32:0] w_sum;
    logic [63:0] w_shl;
    logic [32:0] w_diff;

    always_comb begin
        // Multiply: upper half accumulates, lower half holds the
        // remaining multiplier bits; the carry shifts in at the top.
        w_sum  = {1'b0, i_work[63:32]} + {1'b0, i_opd};
        // Divide: upper half is the partial remainder, lower half
        // shifts the dividend out and the quotient bits in.
        w_shl  = {i_work[62:0], 1'b0};
        w_diff = {1'b0, w_shl[63:32]} - {1'b0, i_opd};
        o_work = i_work;
        if (i_op == OP_MULT) begin
            if (i_work[0]) begin
                o_work = {w_sum, i_work[31:1]};
            end else begin
                o_work = {1'b0, i_work[63:1]};
            end
        end else begin
            // No borrow means the divisor fits: keep the difference.
            if (!w_diff[32]) begin
                o_work = {w_diff[31:0], w_shl[31:1], 1'b1};
            end else begin
                o_work = w_shl;
            end
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed 32x32 multiply / 32/32 divide controller.
// Ports: clk, reset (async, active high), start/op/a/b request inputs;
// busy, done, hi, lo, hi_write, lo_write, div_zero registered outputs.
module mult_div_ctrl
    import cpu_pkg::*;
#(
    parameter int ITER_P = ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hi_write,
    output logic        lo_write,
    output logic        div_zero
);

    localparam logic [4:0] LAST = 5'(ITER_P - 1);

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_op;
    logic [31:0] r_opd;
    logic [63:0] r_work;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [63:0] w_work_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_last;

    md_step u_step (
        .i_op   (r_op),
        .i_opd  (r_opd),
        .i_work (r_work),
        .o_work (w_work_nxt)
    );

    // Sign fixup is applied to the final step's output so the result
    // lands in hi/lo on the same edge that enters FIN.
    always_comb begin
        w_last   = (r_cnt == LAST);
        w_prod   = r_neg_q ? (~w_work_nxt + 64'd1) : w_work_nxt;
        w_quo    = r_neg_q ? (~w_work_nxt[31:0] + 32'd1)
                           : w_work_nxt[31:0];
        w_rem    = r_neg_r ? (~w_work_nxt[63:32] + 32'd1)
                           : w_work_nxt[63:32];
        w_res_hi = (r_op == OP_MULT) ? w_prod[63:32] : w_rem;
        w_res_lo = (r_op == OP_MULT) ? w_prod[31:0]  : w_quo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_op     <= OP_MULT;
            r_opd    <= 32'd0;
            r_work   <= 64'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_cnt   <= 5'd0;
                        r_neg_q <= a[31] ^ b[31];
                        r_neg_r <= a[31];
                        busy    <= 1'b1;
                        if (op == OP_MULT) begin
                            r_opd   <= mag32(a);
                            r_work  <= {32'd0, mag32(b)};
                            r_state <= MULT;
                        end else if (b == 32'd0) begin
                            // Exception path: skip straight to FIN,
                            // hi/lo keep their previous values.
                            r_state  <= FIN;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            r_opd   <= mag32(b);
                            r_work  <= {32'd0, mag32(a)};
                            r_state <= DIV;
                        end
                    end
                end
                MULT, DIV: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_state  <= FIN;
                        done     <= 1'b1;
                        hi_write <= 1'b1;
                        lo_write <= 1'b1;
                        hi       <= w_res_hi;
                        lo       <= w_res_lo;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: scoreboard of expected
// results pushed at issue time and popped when done is observed.
module tb_mult_div_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hi_write;
    logic        lo_write;
    logic        div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          asserts  = 0;
    int          failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; start is sampled at the next rising edge
    // (edge 0). Returns at the following negedge with start dropped.
    task automatic issue(input logic o, input logic [31:0] x,
                         input logic [31:0] y);
        exp_t   e;
        longint p;
        longint q;
        longint r;
        if (o == OP_MULT) begin
            p     = longint'($signed(x)) * longint'($signed(y));
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.dz  = 1'b0;
            e.lat = ITER + 1;
        end else if (y == 32'd0) begin
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            q     = longint'($signed(x)) / longint'($signed(y));
            r     = longint'($signed(x)) % longint'($signed(y));
            e.hi  = r[31:0];
            e.lo  = q[31:0];
            e.dz  = 1'b0;
            e.lat = ITER + 1;
        end
        if (!e.dz) begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        sb.push_back(e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Latency k means done is visible in the cycle after edge k-1,
    // i.e. it is seen at edge +k. -1 means it never came.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= ITER + 8; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        asserts++;
        if ({busy, done, hi, lo, hi_write, lo_write, div_zero} !== 69'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b hi=%h lo=%h want all zero",
                     busy, done, hi, lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        logic [31:0] ta[5] = '{32'h7, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'h0, 32'hFFFF_FFFF};
        logic [31:0] tb[5] = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'h0001_2345, 32'h8000_0000};
        exp_t e;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            issue(OP_MULT, ta[i], tb[i]);
            asserts++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL mult_busy[%0d] got %b want 1", i, busy);
            end
            wait_done(lat);
            e = sb.pop_front();
            asserts++;
            if (lat != e.lat) begin
                failures++;
                $display("FAIL mult_latency[%0d] got %0d want %0d", i, lat, e.lat);
            end
            asserts++;
            if ({hi, lo} !== {e.hi, e.lo}) begin
                failures++;
                $display("FAIL mult_result[%0d] got %h_%h want %h_%h",
                         i, hi, lo, e.hi, e.lo);
            end
            asserts++;
            if ({hi_write, lo_write, div_zero} !== 3'b110) begin
                failures++;
                $display("FAIL mult_strobes[%0d] got %b want 110", i,
                         {hi_write, lo_write, div_zero});
            end
            @(negedge clk);
            asserts++;
            if ({busy, done, hi_write, lo_write} !== 4'b0000) begin
                failures++;
                $display("FAIL mult_after_fin[%0d] got %b want 0000", i,
                         {busy, done, hi_write, lo_write});
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta[6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100,
                               32'd7, 32'hFFFF_FFF9, 32'd5};
        logic [31:0] tb[6] = '{32'd2, 32'hFFFF_FFFF, 32'd7,
                               32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd10};
        exp_t e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            issue(OP_DIV, ta[i], tb[i]);
            wait_done(lat);
            e = sb.pop_front();
            asserts++;
            if (lat != e.lat) begin
                failures++;
                $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, e.lat);
            end
            asserts++;
            if ({hi, lo} !== {e.hi, e.lo}) begin
                failures++;
                $display("FAIL div_result[%0d] got rem=%h quo=%h want rem=%h quo=%h",
                         i, hi, lo, e.hi, e.lo);
            end
            asserts++;
            if ({hi_write, lo_write, div_zero} !== 3'b110) begin
                failures++;
                $display("FAIL div_strobes[%0d] got %b want 110", i,
                         {hi_write, lo_write, div_zero});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int   lat;
        issue(OP_MULT, 32'h0000_1234, 32'hFFFF_5678);
        wait_done(lat);
        e = sb.pop_front();
        asserts++;
        if ({hi, lo} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL dz_prior_mult got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
        end
        @(negedge clk);
        issue(OP_DIV, 32'h0000_0055, 32'd0);
        wait_done(lat);
        e = sb.pop_front();
        asserts++;
        if (lat != e.lat) begin
            failures++;
            $display("FAIL dz_latency got %0d want %0d", lat, e.lat);
        end
        asserts++;
        if ({hi_write, lo_write, div_zero} !== 3'b001) begin
            failures++;
            $display("FAIL dz_strobes got %b want 001", {hi_write, lo_write, div_zero});
        end
        asserts++;
        if ({hi, lo} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL dz_hold got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
        end
        repeat (5) @(negedge clk);
        asserts++;
        if ({busy, done, div_zero, hi, lo} !== {3'b000, m_hi, m_lo}) begin
            failures++;
            $display("FAIL idle_hold got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                     busy, done, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_start_ignored();
        exp_t        e;
        int          ndone = 0;
        int          lat   = -1;
        logic [31:0] got_hi = 32'd0;
        logic [31:0] got_lo = 32'd0;
        issue(OP_MULT, 32'hFFFF_FC18, 32'h0003_0D41);
        for (int k = 1; k <= ITER + 8; k++) begin
            if (done === 1'b1) begin
                ndone++;
                lat    = k;
                got_hi = hi;
                got_lo = lo;
            end
            // A divide-by-zero request would finish at once if it
            // were wrongly accepted.
            start = (k == 5 || k == 20);
            op    = OP_DIV;
            b     = 32'd0;
            @(negedge clk);
            start = 1'b0;
        end
        e = sb.pop_front();
        asserts++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL ignore_done_count got %0d want 1", ndone);
        end
        asserts++;
        if (lat != e.lat) begin
            failures++;
            $display("FAIL ignore_latency got %0d want %0d", lat, e.lat);
        end
        asserts++;
        if ({got_hi, got_lo} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL ignore_result got %h_%h want %h_%h",
                     got_hi, got_lo, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          lat;
        logic        o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 8; i++) begin
            o = 1'($urandom);
            x = $urandom;
            y = (i == 3) ? 32'd0 : $urandom;
            issue(o, x, y);
            wait_done(lat);
            e = sb.pop_front();
            asserts++;
            if (lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
                failures++;
                $display("FAIL b2b[%0d] op=%b a=%h b=%h got lat=%0d %h_%h want lat=%0d %h_%h",
                         i, o, x, y, lat, hi, lo, e.lat, e.hi, e.lo);
            end
            asserts++;
            if (div_zero !== e.dz) begin
                failures++;
                $display("FAIL b2b_dz[%0d] got %b want %b", i, div_zero, e.dz);
            end
            @(negedge clk);
            asserts++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle[%0d] busy got %b want 0", i, busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        int   ndone = 0;
        issue(OP_DIV, 32'd1000, 32'd7);
        void'(sb.pop_back());
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (8) @(negedge clk);
        asserts++;
        if (busy !== 1'b1 || {hi, lo} === 64'd0) begin
            failures++;
            $display("FAIL abort_pre got busy=%b hi=%h lo=%h want busy=1 and hi/lo nonzero",
                     busy, hi, lo);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        asserts++;
        if ({busy, done, hi, lo, hi_write, lo_write} !== 68'd0) begin
            failures++;
            $display("FAIL abort_clear got busy=%b done=%b hi=%h lo=%h want zero",
                     busy, done, hi, lo);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < ITER + 8; k++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        asserts++;
        if (ndone != 0 || {hi, lo} !== 64'd0) begin
            failures++;
            $display("FAIL abort_no_done got %0d dones hi=%h lo=%h want 0 dones zero hi/lo",
                     ndone, hi, lo);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        e = sb.pop_front();
        asserts++;
        if (lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL first_start got lat=%0d %h_%h want lat=%0d %h_%h",
                     lat, hi, lo, e.lat, e.hi, e.lo);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        asserts++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, failures);
        $finish;
    end

endmodule
